// File: rtl/kronos_dmem_slave.sv
// kronos_dmem_slave
// Data-memory responder for the Kronos core's load/store port. It accepts one
// word-aligned request at a time, waits WAIT_STATES cycles, commits the access
// against an internal single-port RAM and then pulses an acknowledge.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (RAM contents are kept)
//   data_addr     byte address; bits [31:2] select the word, [1:0] ignored
//   data_wr_data  write data
//   data_wr_mask  byte enables for writes (bit i -> byte i)
//   data_wr_en    1 = write, 0 = read
//   data_req      request valid, held by the master until it sees data_ack
//   data_rd_data  read data, valid in the ack cycle of a read
//   data_ack      one-cycle completion pulse
//   data_err      out-of-range flag, only meaningful with data_ack
module kronos_dmem_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic        data_err
);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WsLoad  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [30:0] DepthW  = 31'(DEPTH);
  localparam bit          NoWait  = (WAIT_STATES == 0);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic        we_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [29:0]   curIdx;
  logic [31:0]   curWdata;
  logic [3:0]    curMask;
  logic          curWe;
  logic          inRange;
  logic          commit;
  logic          accept;
  logic [AW-1:0] memIdx;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr[1:0];

  // With zero wait states the commit happens on the accepting edge, so the
  // live bus fields are used; otherwise the latched copy is used.
  always_comb begin
    curIdx   = addr_q;
    curWdata = wdata_q;
    curMask  = mask_q;
    curWe    = we_q;
    if (state_q == StIdle) begin
      curIdx   = data_addr[31:2];
      curWdata = data_wr_data;
      curMask  = data_wr_mask;
      curWe    = data_wr_en;
    end
  end

  assign inRange = ({1'b0, curIdx} < DepthW);
  assign memIdx  = curIdx[AW-1:0];
  assign accept  = !rst && (state_q == StIdle) && data_req;
  assign commit  = !rst && (((state_q == StIdle) && data_req && NoWait) ||
                            ((state_q == StWait) && (cnt_q == 4'd0)));

  // Next-state and commit-result logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (data_req) begin
          if (NoWait) begin
            state_d = StAck;
          end else begin
            state_d = StWait;
            cnt_d   = WsLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Writes leave the read-data register untouched.
    if (commit) begin
      err_d = !inRange;
      if (!curWe) begin
        rdata_d = inRange ? mem[memIdx] : 32'h0;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request fields are captured only on acceptance and then held.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= data_addr[31:2];
      wdata_q <= data_wr_data;
      mask_q  <= data_wr_mask;
      we_q    <= data_wr_en;
    end
  end

  // RAM has no reset; out-of-range writes are dropped rather than wrapped.
  always_ff @(posedge clk) begin
    if (commit && curWe && inRange) begin
      for (int b = 0; b < 4; b++) begin
        if (curMask[b]) begin
          mem[memIdx][8*b +: 8] <= curWdata[8*b +: 8];
        end
      end
    end
  end

  assign data_ack     = (state_q == StAck);
  assign data_err     = err_q;
  assign data_rd_data = rdata_q;

endmodule

// File: tb/tb_kronos_dmem_slave.sv
// tb_kronos_dmem_slave
// Drives two instances (no wait states and three wait states, DEPTH=1024)
// with directed and random transactions and compares every ack against a
// simple array model of the memory.
module tb_kronos_dmem_slave;

  logic        clk;
  logic        rst    [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [3:0]  mask   [2];
  logic        we     [2];
  logic        req    [2];
  logic [31:0] rdata  [2];
  logic        ack    [2];
  logic        err    [2];

  logic [31:0] model  [2][1024];
  logic [31:0] lastRd [2];
  bit          held   [2];

  int checks   = 0;
  int failures = 0;

  kronos_dmem_slave #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_addr(addr[0]), .data_wr_data(wdata[0]),
    .data_wr_mask(mask[0]), .data_wr_en(we[0]), .data_req(req[0]),
    .data_rd_data(rdata[0]), .data_ack(ack[0]), .data_err(err[0])
  );

  kronos_dmem_slave #(.DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_addr(addr[1]), .data_wr_data(wdata[1]),
    .data_wr_mask(mask[1]), .data_wr_en(we[1]), .data_req(req[1]),
    .data_rd_data(rdata[1]), .data_ack(ack[1]), .data_err(err[1])
  );

  // 10 ns clock; outputs are sampled 1 ns after each rising edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Holds reset for n cycles, optionally with a write request on the bus.
  task automatic resetDut(input int d, input int n, input bit withReq);
    rst[d] = 1'b1;
    if (withReq) begin
      req[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h0;
      wdata[d] = 32'hFFFF_FFFF; mask[d] = 4'hF;
    end
    repeat (n) begin
      @(posedge clk); #1;
      checkOutput("rstAck", {31'b0, ack[d]}, 32'h0);
      checkOutput("rstErr", {31'b0, err[d]}, 32'h0);
      checkOutput("rstRdData", rdata[d], 32'h0);
    end
    req[d]    = 1'b0;
    rst[d]    = 1'b0;
    lastRd[d] = 32'h0;
    held[d]   = 1'b0;
  endtask

  // One complete transaction: raise the request, wait (bounded) for the ack,
  // then compare latency, error flag and read data with the model.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] m,
                               input bit scramble, input bit dropReq,
                               output logic [31:0] gotRd);
    int   lat;
    int   expLat;
    int   acceptAt;
    bit   seen;
    bit   inr;
    expLat   = wsOf(d) + (held[d] ? 2 : 1);
    acceptAt = held[d] ? 2 : 1;
    addr[d] = a; wdata[d] = wd; mask[d] = m; we[d] = w; req[d] = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) begin
        seen = 1'b1;
      end else begin
        checkOutput("errOutsideAck", {31'b0, err[d]}, 32'h0);
        if (scramble && lat >= acceptAt) begin
          addr[d] = $urandom; wdata[d] = $urandom;
          mask[d] = 4'($urandom); we[d] = 1'($urandom);
        end
      end
    end
    checkOutput("ackLatency", lat, expLat);

    inr = (a[31:2] < 30'd1024);
    if (inr && w) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model[d][a[11:2]][8*b +: 8] = wd[8*b +: 8];
      end
    end
    if (!w) lastRd[d] = inr ? model[d][a[11:2]] : 32'h0;
    checkOutput("ackErr", {31'b0, err[d]}, {31'b0, !inr});
    checkOutput("rdData", rdata[d], lastRd[d]);
    gotRd = rdata[d];

    if (dropReq) begin
      req[d] = 1'b0;
      @(posedge clk); #1;
      checkOutput("ackPulse", {31'b0, ack[d]}, 32'h0);
      held[d] = 1'b0;
    end else begin
      held[d] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [29:0] idx;
    int          r;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0;
      wdata[d] = 32'h0; mask[d] = 4'h0; held[d] = 1'b0; lastRd[d] = 32'h0;
    end
    resetDut(0, 2, 1'b0);
    resetDut(1, 2, 1'b0);

    // Give every word the random phase can read a known value.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 33; i++) begin
        idx = (i == 32) ? 30'd1023 : 30'(i);
        applyStimulus(d, 1'b1, {idx, 2'b00}, $urandom, 4'hF, 1'b0, 1'b1, rd);
      end
    end

    // Reset with a write pending on the bus must not touch word 0.
    resetDut(0, 4, 1'b1);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, rd);

    // Back-to-back write then read with the request held high.
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, rd);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b1, rd);
    checkOutput("rawData", rd, 32'hDEAD_BEEF);

    // Byte masks, including the empty mask.
    applyStimulus(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, rd);
    checkOutput("maskMerge", rd, 32'h11BB_33DD);
    applyStimulus(0, 1'b1, 32'h20, 32'h5555_5555, 4'b0000, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, 1'b1, rd);
    checkOutput("maskEmpty", rd, 32'h11BB_33DD);

    // Range boundary: 0x1000 is word 1024, 0xFFC is the last word.
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, rd);
    applyStimulus(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, 1'b1, rd);

    // Wait states: bus fields wiggle after acceptance and must be ignored.
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1, rd);
    applyStimulus(1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 1'b0, rd);
    applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 1'b1, rd);

    // Reset during the wait window discards a pending write.
    addr[1] = 32'h30; wdata[1] = 32'h1234_5678; mask[1] = 4'hF;
    we[1] = 1'b1; req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1; req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b0; lastRd[1] = 32'h0; held[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checkOutput("noAckAfterRst", {31'b0, ack[1]}, 32'h0);
      @(posedge clk); #1;
    end
    applyStimulus(1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 1'b1, rd);

    // Random traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 60; n++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      idx = 30'd1024 + 30'($urandom_range(0, 31));
        else if (r == 1) idx = 30'd1023;
        else if (r == 2) idx = 30'h3FFF_FC00 + 30'($urandom_range(0, 31));
        else             idx = 30'($urandom_range(0, 31));
        applyStimulus(d, 1'($urandom), {idx, 2'($urandom)}, $urandom,
                      4'($urandom), 1'($urandom), 1'($urandom), rd);
      end
      req[d] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      held[d] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
